// File: rtl/sram_ctrl_if.sv
// Initiator-side bus of the SRAM controller: request/address/data in,
// read data, completion pulse and busy flag out.
interface sram_ctrl_if;
    logic        req;
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;
    logic        busy;

    modport master (output req, we, addr, wdata, input rdata, ack, busy);
    modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> DONE,
// with every strobe and the data-bus enable driven straight from flops.
module sram_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    sram_ctrl_if.slave  bus,
    output logic [19:0] ADDR,
    output logic        CE_N,
    output logic        OE_N,
    output logic        WE_N,
    output logic        UB_N,
    output logic        LB_N,
    output logic [15:0] Data_to_SRAM,
    output logic        data_oe,
    input  logic [15:0] Data_from_SRAM
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        we_r, we_s;
    logic        latch_s, capture_s;
    logic        ack_r, busy_r;
    logic [15:0] rdata_r;
    logic        ce_n_s, oe_n_s, we_n_s, data_oe_s;

    // Next-state, wait counter and request-latch decisions.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        latch_s   = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (bus.req) begin
                    latch_s = 1'b1;
                    state_s = SETUP;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                state_s = ACCESS;
                cnt_s   = CNT_LOAD;
            end
            ACCESS: begin
                if (cnt_r == 4'd0) begin
                    state_s   = DONE;
                    capture_s = ~we_r;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Strobe values for the state being entered; the transfer type is the
    // freshly latched one when a new request is accepted this edge.
    always_comb begin
        if (latch_s) begin
            we_s = bus.we;
        end else begin
            we_s = we_r;
        end
        ce_n_s    = 1'b1;
        oe_n_s    = 1'b1;
        we_n_s    = 1'b1;
        data_oe_s = 1'b0;
        case (state_s)
            SETUP: begin
                ce_n_s    = 1'b0;
                oe_n_s    = we_s;
                data_oe_s = we_s;
            end
            ACCESS: begin
                ce_n_s    = 1'b0;
                oe_n_s    = we_s;
                we_n_s    = ~we_s;
                data_oe_s = we_s;
            end
            DONE: begin
                data_oe_s = we_s;
            end
            default: begin
                ce_n_s = 1'b1;
            end
        endcase
    end

    // State, latched request, read capture and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            we_r         <= 1'b0;
            ADDR         <= 20'd0;
            Data_to_SRAM <= 16'd0;
            rdata_r      <= 16'd0;
            CE_N         <= 1'b1;
            OE_N         <= 1'b1;
            WE_N         <= 1'b1;
            UB_N         <= 1'b1;
            LB_N         <= 1'b1;
            data_oe      <= 1'b0;
            ack_r        <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (latch_s) begin
                ADDR         <= bus.addr;
                Data_to_SRAM <= bus.wdata;
                we_r         <= bus.we;
            end
            if (capture_s) begin
                rdata_r <= Data_from_SRAM;
            end
            CE_N    <= ce_n_s;
            UB_N    <= ce_n_s;
            LB_N    <= ce_n_s;
            OE_N    <= oe_n_s;
            WE_N    <= we_n_s;
            data_oe <= data_oe_s;
            ack_r   <= (state_s == DONE);
            busy_r  <= (state_s != IDLE);
        end
    end

    assign bus.rdata = rdata_r;
    assign bus.ack   = ack_r;
    assign bus.busy  = busy_r;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: cycle table on a WAIT_CYCLES=2 instance, plus
// latency/corner sequences on WAIT_CYCLES=15 and WAIT_CYCLES=1 instances.
module tb_sram_ctrl;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    function automatic logic [15:0] sram_model(input logic [19:0] a);
        if (a == 20'h00012) return 16'h1234;
        else return a[15:0] ^ 16'hA5A5;
    endfunction

    // ---------------- instance with WAIT_CYCLES = 2
    sram_ctrl_if if2();
    logic [19:0] addr2;
    logic ce2, oe2, we2, ub2, lb2, doe2;
    logic [15:0] dto2, dfrom2;
    assign dfrom2 = sram_model(addr2);
    sram_ctrl #(.WAIT_CYCLES(2)) u2 (
        .Clk(Clk), .Reset(Reset), .bus(if2), .ADDR(addr2),
        .CE_N(ce2), .OE_N(oe2), .WE_N(we2), .UB_N(ub2), .LB_N(lb2),
        .Data_to_SRAM(dto2), .data_oe(doe2), .Data_from_SRAM(dfrom2));

    // ---------------- instance with WAIT_CYCLES = 15
    sram_ctrl_if if15();
    logic [19:0] addr15;
    logic ce15, oe15, we15, ub15, lb15, doe15;
    logic [15:0] dto15, dfrom15;
    assign dfrom15 = sram_model(addr15);
    sram_ctrl #(.WAIT_CYCLES(15)) u15 (
        .Clk(Clk), .Reset(Reset), .bus(if15), .ADDR(addr15),
        .CE_N(ce15), .OE_N(oe15), .WE_N(we15), .UB_N(ub15), .LB_N(lb15),
        .Data_to_SRAM(dto15), .data_oe(doe15), .Data_from_SRAM(dfrom15));

    // ---------------- instance with WAIT_CYCLES = 1
    sram_ctrl_if if1();
    logic [19:0] addr1;
    logic ce1, oe1, we1, ub1, lb1, doe1;
    logic [15:0] dto1, dfrom1;
    assign dfrom1 = sram_model(addr1);
    sram_ctrl #(.WAIT_CYCLES(1)) u1 (
        .Clk(Clk), .Reset(Reset), .bus(if1), .ADDR(addr1),
        .CE_N(ce1), .OE_N(oe1), .WE_N(we1), .UB_N(ub1), .LB_N(lb1),
        .Data_to_SRAM(dto1), .data_oe(doe1), .Data_from_SRAM(dfrom1));

    // ctl = {ack, busy, CE_N, OE_N, WE_N, data_oe}
    localparam logic [5:0] C_IDLE  = 6'b001110;
    localparam logic [5:0] C_WSET  = 6'b010111;
    localparam logic [5:0] C_WACC  = 6'b010101;
    localparam logic [5:0] C_WDONE = 6'b111111;
    localparam logic [5:0] C_RACC  = 6'b010010;
    localparam logic [5:0] C_RDONE = 6'b111110;

    typedef struct {
        logic        rst;
        logic        req;
        logic        we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [5:0]  ctl;
        logic [19:0] exp_addr;
        logic [15:0] exp_dto;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;

    task automatic add(input logic rst, input logic req, input logic we,
                       input logic [19:0] addr, input logic [15:0] wdata,
                       input logic [5:0] ctl, input logic [19:0] ea,
                       input logic [15:0] ed, input logic [15:0] er);
        vecs[nvec] = '{rst, req, we, addr, wdata, ctl, ea, ed, er};
        nvec++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [63:0] act, exp;
        int acks, ack_cyc, bad, we_low;

        if2.req = 1'b0;  if2.we = 1'b0;  if2.addr = 20'd0;  if2.wdata = 16'd0;
        if15.req = 1'b0; if15.we = 1'b0; if15.addr = 20'd0; if15.wdata = 16'd0;
        if1.req = 1'b0;  if1.we = 1'b0;  if1.addr = 20'd0;  if1.wdata = 16'd0;

        // reset, then a write aborted by reset in its second ACCESS cycle
        add(1'b1, 1'b0, 1'b0, 20'h00000, 16'h0000, C_IDLE, 20'h00000, 16'h0000, 16'h0000);
        add(1'b0, 1'b0, 1'b0, 20'h00000, 16'h0000, C_IDLE, 20'h00000, 16'h0000, 16'h0000);
        add(1'b0, 1'b1, 1'b1, 20'h0ABCD, 16'h1111, C_WSET, 20'h0ABCD, 16'h1111, 16'h0000);
        add(1'b0, 1'b0, 1'b0, 20'h00000, 16'h0000, C_WACC, 20'h0ABCD, 16'h1111, 16'h0000);
        add(1'b0, 1'b0, 1'b0, 20'h00000, 16'h0000, C_WACC, 20'h0ABCD, 16'h1111, 16'h0000);
        add(1'b1, 1'b1, 1'b1, 20'h00099, 16'h9999, C_IDLE, 20'h00000, 16'h0000, 16'h0000);
        add(1'b0, 1'b0, 1'b0, 20'h00000, 16'h0000, C_IDLE, 20'h00000, 16'h0000, 16'h0000);
        // write 0xBEEF to 0x00012, inputs scrambled and req pulsed during ACCESS
        add(1'b0, 1'b1, 1'b1, 20'h00012, 16'hBEEF, C_WSET, 20'h00012, 16'hBEEF, 16'h0000);
        add(1'b0, 1'b0, 1'b0, 20'h55555, 16'h0000, C_WACC, 20'h00012, 16'hBEEF, 16'h0000);
        add(1'b0, 1'b1, 1'b0, 20'h77777, 16'h0000, C_WACC, 20'h00012, 16'hBEEF, 16'h0000);
        add(1'b0, 1'b0, 1'b0, 20'h00000, 16'h0000, C_WDONE, 20'h00012, 16'hBEEF, 16'h0000);
        add(1'b0, 1'b0, 1'b0, 20'h00000, 16'h0000, C_IDLE, 20'h00012, 16'hBEEF, 16'h0000);
        // read 0x00012 -> 0x1234, held for ten idle cycles
        add(1'b0, 1'b1, 1'b0, 20'h00012, 16'h0000, C_RACC, 20'h00012, 16'h0000, 16'h0000);
        add(1'b0, 1'b0, 1'b0, 20'h00000, 16'h0000, C_RACC, 20'h00012, 16'h0000, 16'h0000);
        add(1'b0, 1'b0, 1'b0, 20'h00000, 16'h0000, C_RACC, 20'h00012, 16'h0000, 16'h0000);
        add(1'b0, 1'b0, 1'b0, 20'h00000, 16'h0000, C_RDONE, 20'h00012, 16'h0000, 16'h1234);
        for (int k = 0; k < 10; k++)
            add(1'b0, 1'b0, 1'b0, 20'h00000, 16'h0000, C_IDLE, 20'h00012, 16'h0000, 16'h1234);
        // back-to-back: write 0x00001 then read 0x00002 with req held high
        add(1'b0, 1'b1, 1'b1, 20'h00001, 16'hCAFE, C_WSET, 20'h00001, 16'hCAFE, 16'h1234);
        add(1'b0, 1'b1, 1'b1, 20'h00001, 16'hCAFE, C_WACC, 20'h00001, 16'hCAFE, 16'h1234);
        add(1'b0, 1'b1, 1'b1, 20'h00001, 16'hCAFE, C_WACC, 20'h00001, 16'hCAFE, 16'h1234);
        add(1'b0, 1'b1, 1'b0, 20'h00002, 16'h0000, C_WDONE, 20'h00001, 16'hCAFE, 16'h1234);
        add(1'b0, 1'b1, 1'b0, 20'h00002, 16'h0000, C_RACC, 20'h00002, 16'h0000, 16'h1234);
        add(1'b0, 1'b0, 1'b0, 20'h00000, 16'h0000, C_RACC, 20'h00002, 16'h0000, 16'h1234);
        add(1'b0, 1'b0, 1'b0, 20'h00000, 16'h0000, C_RACC, 20'h00002, 16'h0000, 16'h1234);
        add(1'b0, 1'b0, 1'b0, 20'h00000, 16'h0000, C_RDONE, 20'h00002, 16'h0000, 16'hA5A7);
        add(1'b0, 1'b0, 1'b0, 20'h00000, 16'h0000, C_IDLE, 20'h00002, 16'h0000, 16'hA5A7);

        for (int i = 0; i < nvec; i++) begin
            @(negedge Clk);
            Reset     = vecs[i].rst;
            if2.req   = vecs[i].req;
            if2.we    = vecs[i].we;
            if2.addr  = vecs[i].addr;
            if2.wdata = vecs[i].wdata;
            @(posedge Clk);
            #1;
            act = {4'd0, if2.ack, if2.busy, ce2, oe2, we2, doe2, ub2, lb2, addr2, dto2, if2.rdata};
            exp = {4'd0, vecs[i].ctl, vecs[i].ctl[3], vecs[i].ctl[3],
                   vecs[i].exp_addr, vecs[i].exp_dto, vecs[i].exp_rdata};
            check($sformatf("vec%0d", i), act, exp);
        end

        // WAIT_CYCLES=15 read of 0x00003 with req/addr/we disturbed mid-ACCESS
        @(negedge Clk);
        Reset = 1'b0;
        if15.req = 1'b1; if15.we = 1'b0; if15.addr = 20'h00003;
        acks = 0; ack_cyc = 0; bad = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge Clk);
            #1;
            if (if15.ack) begin acks++; ack_cyc = c; end
            if (if15.busy && addr15 != 20'h00003) bad++;
            if (we15 == 1'b0) bad++;
            if (c == 1) begin if15.req = 1'b0; if15.addr = 20'h12345; if15.we = 1'b1; end
            if (c == 4) if15.req = 1'b1;
            if (c == 9) if15.req = 1'b0;
        end
        check("w15_ack_cycle", 64'(ack_cyc), 64'd17);
        check("w15_ack_count", 64'(acks), 64'd1);
        check("w15_addr_we_stable", 64'(bad), 64'd0);
        check("w15_rdata", 64'(if15.rdata), 64'h000000000000A5A6);
        check("w15_addr_hold", 64'(addr15), 64'h0000000000000003);

        // WAIT_CYCLES=1 write to the top address 0xFFFFF
        @(negedge Clk);
        if1.req = 1'b1; if1.we = 1'b1; if1.addr = 20'hFFFFF; if1.wdata = 16'h5A5A;
        acks = 0; ack_cyc = 0; bad = 0; we_low = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge Clk);
            #1;
            if (if1.ack) begin acks++; ack_cyc = c; end
            if (we1 == 1'b0) we_low++;
            if (if1.busy && addr1 != 20'hFFFFF) bad++;
            if (c == 3 && (doe1 != 1'b1 || dto1 != 16'h5A5A)) bad++;
            if (c == 1) begin if1.req = 1'b0; if1.addr = 20'h00000; end
        end
        check("w1_ack_cycle", 64'(ack_cyc), 64'd3);
        check("w1_ack_count", 64'(acks), 64'd1);
        check("w1_we_low_cycles", 64'(we_low), 64'd1);
        check("w1_addr_data", 64'(bad), 64'd0);
        check("w1_addr_hold", 64'(addr1), 64'h00000000000FFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
